sd_ddr_rx_sequencer: RTL and testbench

//  Sequences the four DAT-line IDDR capture cells of the SD host in DDR50 read mode.

---
 rtl/sd_ddr_rx_sequencer.sv | 138 +++++++++++++
 tb/tb_sd_ddr_rx_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sd_ddr_rx_sequencer.sv
// rtl/sd_ddr_rx_sequencer.sv - DDR50 read-path sequencer for the four DAT-line IDDR capture cells
module sd_ddr_rx_sequencer #(
    parameter int BLK_W     = 12,
    parameter int TMO_W     = 16,
    parameter int FLUSH_CYC = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [BLK_W-1:0] blk_len_i,
    input  logic [TMO_W-1:0] timeout_i,
    input  logic [3:0]       dat_q1_i,
    input  logic [3:0]       dat_q2_i,
    output logic             iddr_ce_o,
    output logic             iddr_rst_o,
    output logic             busy_o,
    output logic             byte_valid_o,
    output logic [7:0]       byte_o,
    output logic             crc_valid_o,
    output logic             done_o,
    output logic [2:0]       err_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FLUSH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_CRC   = 3'd4;
    localparam logic [2:0] S_ENDB  = 3'd5;

    // Shared by the flush hold and the 16 CRC cycles; wide enough for either.
    localparam int CW = (FLUSH_CYC > 16) ? $clog2(FLUSH_CYC) : 4;

    logic [2:0]       state;
    logic [BLK_W-1:0] byte_cnt;
    logic [TMO_W-1:0] tmo_lim;
    logic [TMO_W-1:0] tmo_cnt;
    logic [CW-1:0]    sub_cnt;

    assign iddr_ce_o  = (state != S_IDLE);
    assign busy_o     = (state != S_IDLE);
    assign iddr_rst_o = (state == S_FLUSH);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= S_IDLE;
            byte_cnt     <= '0;
            tmo_lim      <= '0;
            tmo_cnt      <= '0;
            sub_cnt      <= '0;
            byte_valid_o <= 1'b0;
            crc_valid_o  <= 1'b0;
            byte_o       <= 8'h00;
            done_o       <= 1'b0;
            err_o        <= 3'b000;
        end else begin
            byte_valid_o <= 1'b0;
            crc_valid_o  <= 1'b0;
            done_o       <= 1'b0;
            // Abort drops straight to idle; any byte captured this cycle is never flagged valid.
            if (abort_i) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_i) begin
                            err_o    <= 3'b000;
                            byte_cnt <= blk_len_i;
                            tmo_lim  <= timeout_i;
                            tmo_cnt  <= '0;
                            sub_cnt  <= '0;
                            if (blk_len_i == '0) begin
                                done_o <= 1'b1;
                            end else begin
                                state <= S_FLUSH;
                            end
                        end
                    end
                    S_FLUSH: begin
                        if (sub_cnt == CW'(FLUSH_CYC - 1)) begin
                            sub_cnt <= '0;
                            state   <= S_WAIT;
                        end else begin
                            sub_cnt <= sub_cnt + CW'(1);
                        end
                    end
                    S_WAIT: begin
                        // A start bit is checked first so it beats a timeout landing on the same cycle.
                        if (dat_q1_i == 4'h0) begin
                            if (dat_q2_i == 4'h0) begin
                                state <= S_DATA;
                            end else begin
                                err_o[1] <= 1'b1;
                                done_o   <= 1'b1;
                                state    <= S_IDLE;
                            end
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                            if ((tmo_lim != '0) && (tmo_cnt + TMO_W'(1) == tmo_lim)) begin
                                err_o[0] <= 1'b1;
                                done_o   <= 1'b1;
                                state    <= S_IDLE;
                            end
                        end
                    end
                    S_DATA: begin
                        byte_o       <= {dat_q1_i, dat_q2_i};
                        byte_valid_o <= 1'b1;
                        byte_cnt     <= byte_cnt - BLK_W'(1);
                        if (byte_cnt == BLK_W'(1)) begin
                            sub_cnt <= '0;
                            state   <= S_CRC;
                        end
                    end
                    S_CRC: begin
                        byte_o      <= {dat_q1_i, dat_q2_i};
                        crc_valid_o <= 1'b1;
                        if (sub_cnt == CW'(15)) begin
                            state <= S_ENDB;
                        end else begin
                            sub_cnt <= sub_cnt + CW'(1);
                        end
                    end
                    S_ENDB: begin
                        if (dat_q1_i != 4'hF) begin
                            err_o[2] <= 1'b1;
                        end
                        done_o <= 1'b1;
                        state  <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sd_ddr_rx_sequencer.sv
// tb/tb_sd_ddr_rx_sequencer.sv - randomized self-checking bench for sd_ddr_rx_sequencer
module tb_sd_ddr_rx_sequencer;

    localparam int BLK_W = 12;
    localparam int TMO_W = 16;
    localparam int FL    = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [BLK_W-1:0] blk_len = '0;
    logic [TMO_W-1:0] tmo = '0;
    logic [3:0]       q1 = 4'h0;
    logic [3:0]       q2 = 4'h0;
    logic             iddr_ce, iddr_rst, busy, byte_valid, crc_valid, done;
    logic [7:0]       byte_out;
    logic [2:0]       err;

    sd_ddr_rx_sequencer #(.BLK_W(BLK_W), .TMO_W(TMO_W), .FLUSH_CYC(FL)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
        .blk_len_i(blk_len), .timeout_i(tmo), .dat_q1_i(q1), .dat_q2_i(q2),
        .iddr_ce_o(iddr_ce), .iddr_rst_o(iddr_rst), .busy_o(busy),
        .byte_valid_o(byte_valid), .byte_o(byte_out), .crc_valid_o(crc_valid),
        .done_o(done), .err_o(err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Line pairs {q1,q2} presented from the first WAIT_START cycle onward.
    logic [7:0] stim[$];
    logic [7:0] exp_bytes[$];
    logic [7:0] exp_crc[$];
    logic [7:0] got_bytes[$];
    logic [7:0] got_crc[$];

    // kind: 0 good block, 1 bad start bit, 2 no start bit (timeout), 3 bad end bit
    task automatic build_stim(input int kind, input int p, input int len);
        stim.delete();
        for (int i = 0; i < p; i++) stim.push_back({4'($urandom_range(1, 15)), 4'($urandom)});
        if (kind == 1) stim.push_back({4'h0, 4'($urandom_range(1, 15))});
        else if (kind == 2) stim.push_back({4'($urandom_range(1, 15)), 4'($urandom)});
        else stim.push_back(8'h00);
        for (int i = 0; i < len + 16; i++) stim.push_back(8'($urandom));
        if (kind == 3) stim.push_back({4'($urandom_range(0, 14)), 4'($urandom)});
        else stim.push_back({4'hF, 4'($urandom)});
        for (int i = 0; i < 3; i++) stim.push_back(8'hFF);
    endtask

    // kill_at: iteration whose drive carries abort (or a reset pulse); 0 = none.
    task automatic run_txn(input string name, input int len, input int tmo_v,
                           input int kill_at, input bit kill_rst);
        int  ws, done_t, exp_err, t_end, got_done_t, done_cnt, rst_cyc, ce_cyc, overlap, exp_ce;
        bit  found, exp_done;
        ws = 0; done_t = 0; exp_err = 0; found = 0;
        got_done_t = 0; done_cnt = 0; rst_cyc = 0; ce_cyc = 0; overlap = 0;
        exp_bytes.delete(); exp_crc.delete(); got_bytes.delete(); got_crc.delete();

        // Reference: scan the line sequence by the protocol rules; cycle n of WAIT_START is edge FL+1+n.
        if (len == 0) done_t = 1;
        else begin
            for (int w = 0; w < stim.size() && done_t == 0 && !found; w++) begin
                if (stim[w][7:4] == 4'h0) begin
                    if (stim[w][3:0] == 4'h0) begin found = 1; ws = w; end
                    else begin exp_err = 2; done_t = FL + 2 + w; end
                end else if (tmo_v != 0 && w + 1 == tmo_v) begin
                    exp_err = 1; done_t = FL + 2 + w;
                end
            end
        end
        if (found) begin
            for (int i = 0; i < len; i++)
                if (kill_at == 0 || FL + 2 + ws + i < kill_at) exp_bytes.push_back(stim[ws + 1 + i]);
            for (int i = 0; i < 16; i++)
                if (kill_at == 0 || FL + 2 + ws + len + i < kill_at) exp_crc.push_back(stim[ws + 1 + len + i]);
            if (stim[ws + 1 + len + 16][7:4] != 4'hF) exp_err = 4;
            done_t = FL + 3 + ws + len + 16;
        end
        exp_done = 1;
        if (kill_at != 0 && done_t - 1 >= kill_at) begin exp_done = 0; exp_err = 0; end
        exp_ce = (len == 0) ? 0 : (exp_done ? done_t - 1 : kill_at);
        t_end  = exp_done ? done_t + 2 : kill_at + 3;

        @(negedge clk);
        start = 1'b1; blk_len = BLK_W'(len); tmo = TMO_W'(tmo_v);
        q1 = 4'($urandom); q2 = 4'($urandom);
        for (int t = 1; t <= t_end + 50 && t <= 2000; t++) begin
            if (t > t_end) break;
            @(negedge clk);
            if (byte_valid) got_bytes.push_back(byte_out);
            if (crc_valid) got_crc.push_back(byte_out);
            if (byte_valid && crc_valid) overlap++;
            if (done) begin done_cnt++; got_done_t = t; end
            if (iddr_rst) rst_cyc++;
            if (iddr_ce) ce_cyc++;
            start = 1'b0; abort = 1'b0; rst_n = 1'b1;
            if (t >= FL + 1 && t - FL - 1 < stim.size()) {q1, q2} = stim[t - FL - 1];
            else begin q1 = 4'hF; q2 = 4'($urandom); end
            if (t == kill_at) begin
                if (kill_rst) begin
                    rst_n = 1'b0;
                    #1;
                    check({name, "_reset_outputs"},
                          {9'd0, busy, iddr_ce, iddr_rst, byte_valid, crc_valid, done, err, byte_out}, 32'd0);
                end else abort = 1'b1;
            end
        end
        @(negedge clk);
        abort = 1'b0; rst_n = 1'b1;

        check({name, "_done_count"}, done_cnt, exp_done ? 1 : 0);
        if (exp_done) check({name, "_done_cycle"}, got_done_t, done_t);
        check({name, "_err"}, {29'd0, err}, exp_err);
        check({name, "_byte_count"}, got_bytes.size(), exp_bytes.size());
        for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++)
            check({name, "_byte"}, {24'd0, got_bytes[i]}, {24'd0, exp_bytes[i]});
        check({name, "_crc_count"}, got_crc.size(), exp_crc.size());
        for (int i = 0; i < got_crc.size() && i < exp_crc.size(); i++)
            check({name, "_crc"}, {24'd0, got_crc[i]}, {24'd0, exp_crc[i]});
        check({name, "_rst_cycles"}, rst_cyc, (len == 0) ? 0 : FL);
        check({name, "_ce_cycles"}, ce_cyc, exp_ce);
        check({name, "_valid_overlap"}, overlap, 0);
        check({name, "_idle_after"}, {30'd0, busy, iddr_ce}, 0);
    endtask

    initial begin
        int kind, p, len, tv;
        repeat (3) @(negedge clk);
        check("reset_state",
              {9'd0, busy, iddr_ce, iddr_rst, byte_valid, crc_valid, done, err, byte_out}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Good block with known leading bytes after three idle-high cycles.
        build_stim(0, 3, 4);
        for (int i = 0; i < 3; i++) stim[i] = 8'hFF;
        stim[4] = 8'hA5; stim[5] = 8'h12; stim[6] = 8'h34;
        run_txn("basic", 4, 0, 0, 0);
        check("basic_first_byte", {24'd0, got_bytes.size() > 0 ? got_bytes[0] : 8'h00}, 32'hA5);

        // Lines held high: timeout after exactly 10 WAIT_START cycles.
        build_stim(2, 14, 4);
        for (int i = 0; i < 14; i++) stim[i] = 8'hFF;
        run_txn("timeout", 4, 10, 0, 0);

        build_stim(1, 2, 4);
        stim[2] = 8'h03;
        run_txn("bad_start", 4, 0, 0, 0);

        build_stim(3, 1, 4);
        stim[1 + 1 + 4 + 16] = 8'h70;
        run_txn("bad_endbit", 4, 0, 0, 0);

        // start and abort together in IDLE: abort wins and the sticky error survives.
        @(negedge clk);
        start = 1'b1; abort = 1'b1; blk_len = 12'd4;
        @(negedge clk);
        check("start_abort_busy", {31'd0, busy}, 0);
        check("start_abort_err_kept", {29'd0, err}, 32'd4);
        start = 1'b0; abort = 1'b0;

        // Abort on the second data byte, then a clean block.
        build_stim(0, 2, 6);
        run_txn("abort_data", 6, 0, FL + 1 + 2 + 2, 0);
        build_stim(0, 1, 3);
        run_txn("after_abort", 3, 0, 0, 0);

        build_stim(0, 0, 4);
        run_txn("zero_len", 0, 0, 0, 0);

        build_stim(0, 2, 8);
        run_txn("reset_mid", 8, 0, FL + 1 + 2 + 4, 1);

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 3);
            len  = $urandom_range(1, 8);
            p    = $urandom_range(0, 6);
            if (kind == 2) begin
                tv = $urandom_range(1, 6);
                p  = tv + $urandom_range(0, 3);
            end else begin
                tv = ($urandom_range(0, 1) == 0) ? 0 : p + 1 + $urandom_range(0, 5);
            end
            build_stim(kind, p, len);
            run_txn("random", len, tv, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
